tag_reorder_buffer: RTL and testbench
=====================================

TAG_REORDER_BUFFER -- requirements
Module: tag_reorder_buffer

Interface
REQ-001 SHALL have parameter NumTags, default 8, number of tags tracked (>1).
REQ-002 SHALL have parameter DataWidth, default 32, completion payload width.
REQ-003 SHALL have dependent parameters TagWidth = $clog2(NumTags) and tag_t = logic [TagWidth-1:0], not to be overridden.
REQ-004 SHALL have port clk_i  input  1  clock; one clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port alloc_valid_i  input  1  a tag was issued this cycle.
REQ-007 SHALL have port alloc_tag_i  input  TagWidth  issued tag, recorded in issue order.
REQ-008 SHALL have port done_valid_i  input  1  out-of-order completion arrives; always accepted.
REQ-009 SHALL have port done_tag_i  input  TagWidth  tag of completion.
REQ-010 SHALL have port done_data_i  input  DataWidth  completion payload.
REQ-011 SHALL have port out_valid_o  output  1  in-order result available.
REQ-012 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-013 SHALL have port out_tag_o  output  TagWidth  tag of presented result.
REQ-014 SHALL have port out_data_o  output  DataWidth  payload of presented result.
REQ-015 SHALL have port free_o  output  1  release tag back to tag allocator.
REQ-016 SHALL have port free_tag_o  output  TagWidth  tag being released.
REQ-017 SHALL have port count_o  output  $clog2(NumTags+1)  tags outstanding (allocated, not yet released).

Function
REQ-018 SHALL keep an issue-order circular FIFO of NumTags tag entries with read/write pointers wrapping at NumTags and an occupancy counter.
REQ-019 SHALL keep per-tag state: alloc bit, done bit, DataWidth data register.
REQ-020 SHALL, on alloc_valid_i with FIFO not full (or full with pop same cycle), push alloc_tag_i, set alloc bit, clear done bit.
REQ-021 SHALL ignore alloc_valid_i when full and no pop occurs that cycle; state unchanged.
REQ-022 SHALL, on done_valid_i for a tag with alloc bit set and done bit clear, store done_data_i and set done bit at next edge.
REQ-023 SHALL ignore done_valid_i for a tag with alloc bit clear or done bit already set.
REQ-024 SHALL drive out_valid_o = FIFO non-empty AND done bit of head tag, from registered state only (no bypass of done_*); minimum latency done at cycle N -> out_valid_o at N+1.
REQ-025 SHALL drive out_tag_o = head tag and out_data_o = head data while out_valid_o high, else both 0.
REQ-026 SHALL hold out_valid_o, out_tag_o, out_data_o stable until out_valid_o && out_ready_i.
REQ-027 SHALL, on handshake, pop head, clear its alloc and done bits at next edge.
REQ-028 SHALL drive free_o = out_valid_o && out_ready_i combinationally, free_tag_o = head tag when free_o high else 0.
REQ-029 SHALL allow push, pop and completion in one cycle; count_o += push, -= pop; completion for the tag just pushed in the same cycle is ignored (alloc bit not yet set).
REQ-030 SHALL allow re-allocation of a tag in the cycle after its release; stale done/data never visible.
REQ-031 SHALL present count_o as registered occupancy, range 0..NumTags.

Reset
REQ-032 SHALL, while rst_ni low, clear pointers, counter, alloc and done bits; outputs out_valid_o=0, out_tag_o=0, out_data_o=0, free_o=0, free_tag_o=0, count_o=0.
REQ-033 SHALL discard all outstanding tags on reset asserted mid-operation; data registers need no reset.
REQ-034 SHALL, outside SYNTHESIS, assert: no alloc when full without pop, no alloc of tag with alloc bit set, no done for unallocated tag, out_* stable while valid and not ready.

Verification (NumTags=4, DataWidth=8)
REQ-035 SHALL cover in-order: alloc 0,1; done 0/0xAA, 1/0xBB; ready high -> out 0/0xAA then 1/0xBB, free_o pulses tags 0,1, count_o 2->0.
REQ-036 SHALL cover reorder: alloc 2,0,3; done 3/0x33, 0/0x00, then 2/0x22 -> no out_valid_o until done 2 +1 cycle, then tags 2,0,3 back-to-back.
REQ-037 SHALL cover full: alloc 0..3, count_o=4, extra alloc ignored; pop head with simultaneous alloc of released tag -> count_o stays 4.
REQ-038 SHALL cover backpressure: head done, out_ready_i low 5 cycles -> out_valid_o, tag, data held, free_o 0; ready high -> single free_o pulse.
REQ-039 SHALL cover illegal done: done for unallocated tag 1 -> ignored, no out_valid_o; duplicate done for tag 0 -> first data kept.
REQ-040 SHALL cover reset mid-operation: 3 tags outstanding, 2 done, rst_ni low 1 cycle -> all outputs 0, count_o=0, stale tags never emitted.

Source files
------------

// File: rtl/tag_reorder_buffer.sv
// tag_reorder_buffer: returns out-of-order completions to the consumer in tag issue order.
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   alloc_valid_i, alloc_tag_i       tag issued this cycle, recorded in issue order
//   done_valid_i, done_tag_i,
//   done_data_i                      out-of-order completion with payload, always accepted
//   out_valid_o, out_ready_i,
//   out_tag_o, out_data_o            in-order result handshake
//   free_o, free_tag_o               tag released back to the allocator on handshake
//   count_o                          tags outstanding (allocated, not yet released)
module tag_reorder_buffer #(
   parameter int NumTags = 8,
   parameter int DataWidth = 32,
   localparam int TagWidth = $clog2(NumTags),
   localparam int CntWidth = $clog2(NumTags + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 alloc_valid_i,
   input  logic [TagWidth-1:0]  alloc_tag_i,
   input  logic                 done_valid_i,
   input  logic [TagWidth-1:0]  done_tag_i,
   input  logic [DataWidth-1:0] done_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [TagWidth-1:0]  out_tag_o,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 free_o,
   output logic [TagWidth-1:0]  free_tag_o,
   output logic [CntWidth-1:0]  count_o
);
   typedef logic [TagWidth-1:0] tag_t;

   tag_t                 fifo_q [NumTags];
   logic [DataWidth-1:0] data_q [NumTags];
   tag_t                 rd_ptr_q, wr_ptr_q;
   logic [CntWidth-1:0]  count_q;
   logic [NumTags-1:0]   alloc_q, done_q;
   tag_t                 head;
   logic                 full, pop, push, done_ok;

   function automatic tag_t wrap_inc(tag_t p);
      return (p == tag_t'(NumTags - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head        = fifo_q[rd_ptr_q];
   assign full        = count_q == CntWidth'(NumTags);
   assign out_valid_o = (count_q != '0) && done_q[head];
   assign pop         = out_valid_o && out_ready_i;
   // a full buffer can still take an alloc when the head leaves in the same cycle
   assign push        = alloc_valid_i && (!full || pop);
   // the alloc bit is registered, so a completion for a tag pushed this cycle is dropped
   assign done_ok     = done_valid_i && alloc_q[done_tag_i] && !done_q[done_tag_i];
   assign out_tag_o   = out_valid_o ? head : '0;
   assign out_data_o  = out_valid_o ? data_q[head] : '0;
   assign free_o      = pop;
   assign free_tag_o  = pop ? head : '0;
   assign count_o     = count_q;

   // the push update comes last so a tag released and re-issued in one cycle ends up allocated
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         alloc_q  <= '0;
         done_q   <= '0;
      end else begin
         if (pop) begin
            rd_ptr_q      <= wrap_inc(rd_ptr_q);
            alloc_q[head] <= 1'b0;
            done_q[head]  <= 1'b0;
         end
         if (done_ok) done_q[done_tag_i] <= 1'b1;
         if (push) begin
            wr_ptr_q             <= wrap_inc(wr_ptr_q);
            alloc_q[alloc_tag_i] <= 1'b1;
            done_q[alloc_tag_i]  <= 1'b0;
         end
         count_q <= count_q + CntWidth'(push) - CntWidth'(pop);
      end
   end

   // storage is qualified by the alloc/done bits, so it needs no reset
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= alloc_tag_i;
      if (done_ok) data_q[done_tag_i] <= done_data_i;
   end

`ifndef SYNTHESIS
   a_full_alloc: assert property (@(posedge clk_i) disable iff (!rst_ni)
      alloc_valid_i && full |-> pop)
      else $warning("alloc while full dropped");
   a_dup_alloc: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> !alloc_q[alloc_tag_i] || (pop && head == alloc_tag_i));
   a_done_unalloc: assert property (@(posedge clk_i) disable iff (!rst_ni)
      done_valid_i |-> alloc_q[done_tag_i])
      else $warning("completion for unallocated tag dropped");
   a_out_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      out_valid_o && !out_ready_i |=> out_valid_o && $stable(out_tag_o) && $stable(out_data_o));
`endif
endmodule

// File: tb/tb_tag_reorder_buffer.sv
// tb_tag_reorder_buffer: directed scoreboard bench for tag_reorder_buffer (NumTags=4, DataWidth=8).
module tb_tag_reorder_buffer;
   logic       clk_i = 1'b0, rst_ni = 1'b0;
   logic       alloc_valid_i = 1'b0, done_valid_i = 1'b0, out_ready_i = 1'b0;
   logic [1:0] alloc_tag_i = '0, done_tag_i = '0;
   logic [7:0] done_data_i = '0;
   logic       out_valid_o, free_o;
   logic [1:0] out_tag_o, free_tag_o;
   logic [7:0] out_data_o;
   logic [2:0] count_o;
   int         tests = 0, fails = 0;
   logic [9:0] exp_q [$];
   logic [9:0] e;

   tag_reorder_buffer #(.NumTags(4), .DataWidth(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .alloc_valid_i(alloc_valid_i), .alloc_tag_i(alloc_tag_i),
      .done_valid_i(done_valid_i), .done_tag_i(done_tag_i), .done_data_i(done_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_tag_o(out_tag_o), .out_data_o(out_data_o),
      .free_o(free_o), .free_tag_o(free_tag_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // monitor: every handshake must match the next expected in-order result
   always @(negedge clk_i) begin
      if (rst_ni && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got tag %0d data %0h, expected no output", out_tag_o, out_data_o);
         end else begin
            e = exp_q.pop_front();
            chk("out_tag", 32'(out_tag_o), 32'(e[9:8]));
            chk("out_data", 32'(out_data_o), 32'(e[7:0]));
            chk("free_o", 32'(free_o), 32'd1);
            chk("free_tag", 32'(free_tag_o), 32'(e[9:8]));
         end
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic alloc(int t);
      alloc_valid_i = 1'b1;
      alloc_tag_i   = 2'(t);
      cyc();
      alloc_valid_i = 1'b0;
   endtask

   task automatic done(int t, int d);
      done_valid_i = 1'b1;
      done_tag_i   = 2'(t);
      done_data_i  = 8'(d);
      cyc();
      done_valid_i = 1'b0;
   endtask

   task automatic expect_out(int t, int d);
      exp_q.push_back({2'(t), 8'(d)});
   endtask

   task automatic chk_idle(string name);
      chk({name, "_valid"}, 32'(out_valid_o), 32'd0);
      chk({name, "_tag"}, 32'(out_tag_o), 32'd0);
      chk({name, "_data"}, 32'(out_data_o), 32'd0);
      chk({name, "_free"}, 32'(free_o), 32'd0);
      chk({name, "_free_tag"}, 32'(free_tag_o), 32'd0);
      chk({name, "_count"}, 32'(count_o), 32'd0);
   endtask

   initial begin
      cyc(2);
      chk_idle("reset");
      rst_ni = 1'b1;
      cyc();

      // in order
      out_ready_i = 1'b1;
      alloc(0);
      alloc(1);
      chk("inorder_count2", 32'(count_o), 32'd2);
      expect_out(0, 8'hAA);
      expect_out(1, 8'hBB);
      done(0, 8'hAA);
      done(1, 8'hBB);
      cyc(2);
      chk("inorder_count0", 32'(count_o), 32'd0);

      // reorder
      alloc(2);
      alloc(0);
      alloc(3);
      expect_out(2, 8'h22);
      expect_out(0, 8'h00);
      expect_out(3, 8'h33);
      done(3, 8'h33);
      chk("reorder_wait3", 32'(out_valid_o), 32'd0);
      done(0, 8'h00);
      chk("reorder_wait0", 32'(out_valid_o), 32'd0);
      done(2, 8'h22);
      chk("reorder_latency", 32'(out_valid_o), 32'd1);
      chk("reorder_head", 32'(out_tag_o), 32'd2);
      cyc();
      chk("reorder_b2b_tag", 32'(out_tag_o), 32'd0);
      chk("reorder_b2b_count", 32'(count_o), 32'd2);
      cyc(2);
      chk("reorder_count0", 32'(count_o), 32'd0);

      // full
      out_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) alloc(i);
      chk("full_count4", 32'(count_o), 32'd4);
      alloc(1);
      chk("full_extra_ignored", 32'(count_o), 32'd4);
      done(0, 8'h10);
      chk("full_head_valid", 32'(out_valid_o), 32'd1);
      expect_out(0, 8'h10);
      out_ready_i   = 1'b1;
      alloc_valid_i = 1'b1;
      alloc_tag_i   = 2'd0;
      cyc();
      alloc_valid_i = 1'b0;
      out_ready_i   = 1'b0;
      chk("full_pop_push_count", 32'(count_o), 32'd4);
      chk("full_realloc_not_done", 32'(out_valid_o), 32'd0);
      expect_out(1, 8'h11);
      expect_out(2, 8'h12);
      expect_out(3, 8'h13);
      expect_out(0, 8'h14);
      out_ready_i = 1'b1;
      done(0, 8'h14);
      done(3, 8'h13);
      done(2, 8'h12);
      chk("full_head1_wait", 32'(out_valid_o), 32'd0);
      done(1, 8'h11);
      cyc(4);
      chk("full_drain_count", 32'(count_o), 32'd0);

      // backpressure
      out_ready_i = 1'b0;
      alloc(1);
      done(1, 8'h5A);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(out_valid_o), 32'd1);
         chk("bp_tag", 32'(out_tag_o), 32'd1);
         chk("bp_data", 32'(out_data_o), 32'h5A);
         chk("bp_free", 32'(free_o), 32'd0);
         cyc();
      end
      expect_out(1, 8'h5A);
      out_ready_i = 1'b1;
      cyc();
      chk("bp_after_valid", 32'(out_valid_o), 32'd0);
      chk("bp_single_free", 32'(free_o), 32'd0);
      chk("bp_count", 32'(count_o), 32'd0);

      // illegal completions
      done(1, 8'h77);
      chk("unalloc_done_valid", 32'(out_valid_o), 32'd0);
      chk("unalloc_done_count", 32'(count_o), 32'd0);
      out_ready_i = 1'b0;
      alloc(0);
      done(0, 8'hC3);
      done(0, 8'h3C);
      chk("dup_done_data", 32'(out_data_o), 32'hC3);
      expect_out(0, 8'hC3);
      out_ready_i = 1'b1;
      cyc();
      chk("dup_done_count", 32'(count_o), 32'd0);

      // reset mid-operation
      out_ready_i = 1'b0;
      alloc(0);
      alloc(1);
      alloc(2);
      done(0, 8'h01);
      done(2, 8'h02);
      chk("midrst_valid_before", 32'(out_valid_o), 32'd1);
      chk("midrst_count_before", 32'(count_o), 32'd3);
      rst_ni      = 1'b0;
      out_ready_i = 1'b1;
      #1;
      chk_idle("midrst");
      cyc();
      rst_ni = 1'b1;
      cyc(4);
      chk("midrst_no_stale", 32'(out_valid_o), 32'd0);
      chk("midrst_count_after", 32'(count_o), 32'd0);
      expect_out(2, 8'h99);
      alloc(2);
      done(2, 8'h99);
      cyc(2);
      chk("midrst_realloc_count", 32'(count_o), 32'd0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
